buffer_load_ctrl: RTL and testbench
===================================

// Module: buffer_load_ctrl
// PURPOSE
//  Load controller that sits directly upstream of sequence_buffer. Accepts INPUT_WIDTH-wide
//  query/database chunks from the host over a valid/ready handshake and drives wr_en_buff and
//  count so each chunk lands in the correct buffer register. After the last chunk it pulses
//  core_start to the alignment matrix, then holds off new loads until core_done.
// PARAMETERS
//  SEQ_LENGTH     32  letters per sequence
//  LETTER_WIDTH   2   bits per letter
//  INPUT_WIDTH    8   bits per input chunk; must divide SEQ_LENGTH*LETTER_WIDTH
//  NUM_BUFF_REGS  8   chunks per sequence = SEQ_LENGTH*LETTER_WIDTH/INPUT_WIDTH
//  BUFF_CNT_W     3   count width = $clog2(NUM_BUFF_REGS)
// PORTS
//  clk         in   1           system clock, rising edge
//  rst_n       in   1           asynchronous active-low reset
//  start       in   1           request a new load; sampled only in IDLE
//  in_valid    in   1           host chunk present on query_seq_in/database_seq_in
//  in_ready    out  1           controller can accept a chunk this cycle
//  wr_en_buff  out  1           to sequence_buffer: write the current chunk this cycle
//  count       out  BUFF_CNT_W  to sequence_buffer: index of the register being written
//  core_start  out  1           one-cycle pulse: buffer full, matrix may start
//  core_done   in   1           matrix finished; releases the controller
//  busy        out  1           high whenever state != IDLE
// BEHAVIOUR
//  Clock and reset: single clock clk; reset rst_n is asynchronous and active-low.
//  Reset: state=IDLE, count=0, core_start=0. in_ready, wr_en_buff and busy are 0 while rst_n=0.
//  FSM states: IDLE, LOAD, DONE, RUN (registered state).
//   IDLE: in_ready=0, wr_en_buff=0, count=0. start=1 -> LOAD next edge. in_valid ignored.
//   LOAD: in_ready=1. wr_en_buff = in_valid (combinational, same cycle).
//    Accepted beat (in_valid & in_ready) on edge:
//     - count<NUM_BUFF_REGS-1: count<=count+1.
//     - count==NUM_BUFF_REGS-1: count<=0, state<=DONE.
//    No beat: count and state hold. Gaps of any length are allowed.
//   DONE: one cycle only. core_start=1, in_ready=0. -> RUN.
//   RUN: in_ready=0. core_done=1 -> IDLE. start is ignored.
//  count is a register and is stable for the whole cycle in which wr_en_buff=1.
//   sequence_buffer captures the chunk on the same edge that advances count.
//  count never exceeds NUM_BUFF_REGS-1. It wraps to 0 only on the final beat.
//  Latency:
//   start sampled at edge k -> LOAD from cycle k+1. First beat can be accepted in cycle k+1.
//   Last beat accepted at edge m -> core_start high during cycle m+1.
//   Minimum start-to-core_start = NUM_BUFF_REGS+1 cycles.
//  core_start is a decode of registered state DONE, so it is glitch-free and exactly 1 cycle.
//  Simultaneous events:
//   - start together with core_done in RUN: go to IDLE; start is dropped and must be re-issued.
//   - core_done outside RUN: ignored.
//   - start outside IDLE: ignored, never queued.
//  Reset during LOAD: the controller returns to IDLE asynchronously. The partial load is
//   abandoned; the next start reloads from count=0 and overwrites every register.
//  busy = (state != IDLE).
// TESTING
//  1 Reset: assert rst_n=0 mid-cycle -> count=0, wr_en_buff=0, in_ready=0, core_start=0, busy=0
//    immediately.
//  2 Back-to-back load: start pulse, in_valid=1 for 8 cycles, chunks 0x11..0x88 ->
//    wr_en_buff=1 for 8 cycles with count 0..7; buffer reg i = chunk i; core_start=1 for exactly
//    the next cycle; in_ready=0 afterwards.
//  3 Gapped load: in_valid pattern 1,0,1,0,... -> count advances only on valid cycles;
//    wr_en_buff=0 in gaps; core_start appears one cycle after the 8th beat (16 cycles after
//    LOAD entry).
//  4 Start while busy: start pulsed during LOAD and RUN -> no effect. core_done -> IDLE next
//    cycle; a new start reloads from count=0.
//  5 Mid-load reset: rst_n low after 3 beats -> outputs 0 at once; after release, start plus
//    8 beats completes normally with count 0..7.
//  6 Idle noise: in_valid=1 held in IDLE and RUN -> wr_en_buff stays 0, in_ready stays 0,
//    count stays 0.

Source files
------------

// File: rtl/buffer_load_ctrl_if.sv
// Host/matrix handshake bundle for buffer_load_ctrl: load request, chunk handshake,
// sequence_buffer write controls and the core start/done pair.
interface buffer_load_ctrl_if #(
    parameter int BUFF_CNT_W = 3
);
    logic                  start;
    logic                  in_valid;
    logic                  in_ready;
    logic                  wr_en_buff;
    logic [BUFF_CNT_W-1:0] count;
    logic                  core_start;
    logic                  core_done;
    logic                  busy;

    modport master (
        output start, in_valid, core_done,
        input  in_ready, wr_en_buff, count, core_start, busy
    );

    modport slave (
        input  start, in_valid, core_done,
        output in_ready, wr_en_buff, count, core_start, busy
    );
endinterface

// File: rtl/buffer_load_ctrl.sv
// Load controller feeding sequence_buffer: steps count through every chunk register,
// pulses core_start once the buffer is full, then waits for core_done.
module buffer_load_ctrl #(
    parameter int SEQ_LENGTH    = 32,
    parameter int LETTER_WIDTH  = 2,
    parameter int INPUT_WIDTH   = 8,
    parameter int NUM_BUFF_REGS = SEQ_LENGTH * LETTER_WIDTH / INPUT_WIDTH,
    parameter int BUFF_CNT_W    = $clog2(NUM_BUFF_REGS)
) (
    input logic                clk,
    input logic                rst_n,
    buffer_load_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    localparam logic [BUFF_CNT_W-1:0] LAST_IDX = BUFF_CNT_W'(NUM_BUFF_REGS - 1);
    localparam logic [BUFF_CNT_W-1:0] CNT_ZERO = {BUFF_CNT_W{1'b0}};
    localparam logic [BUFF_CNT_W-1:0] CNT_ONE  = BUFF_CNT_W'(1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [BUFF_CNT_W-1:0] r_count;
    logic [BUFF_CNT_W-1:0] w_count_nxt;
    logic                  w_beat;
    logic                  w_in_ready;
    logic                  w_wr_en;
    logic                  w_core_start;
    logic                  w_busy;

    // State and write-index registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_count <= CNT_ZERO;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Next-state and write-index decode; count only moves on accepted beats
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        case (r_state)
            ST_IDLE: begin
                w_count_nxt = CNT_ZERO;
                if (bus.start) begin
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (w_beat) begin
                    if (r_count == LAST_IDX) begin
                        w_count_nxt = CNT_ZERO;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_count_nxt = r_count + CNT_ONE;
                        w_state_nxt = ST_LOAD;
                    end
                end else begin
                    w_count_nxt = r_count;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                // start arriving with core_done is deliberately dropped
                if (bus.core_done) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_count_nxt = CNT_ZERO;
            end
        endcase
    end

    // Output decode from the registered state only, so core_start cannot glitch
    always_comb begin
        w_in_ready   = 1'b0;
        w_core_start = 1'b0;
        w_busy       = 1'b0;
        w_beat       = 1'b0;
        w_wr_en      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
            end
            ST_LOAD: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b1;
                w_beat     = bus.in_valid;
                w_wr_en    = bus.in_valid;
            end
            ST_DONE: begin
                w_core_start = 1'b1;
                w_busy       = 1'b1;
            end
            ST_RUN: begin
                w_busy = 1'b1;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.wr_en_buff = w_wr_en;
    assign bus.count      = r_count;
    assign bus.core_start = w_core_start;
    assign bus.busy       = w_busy;

endmodule

// File: tb/tb_buffer_load_ctrl.sv
// Scoreboard bench for buffer_load_ctrl: directed scenarios plus randomized traffic,
// with expectations from a transaction-level model of the load protocol.
module tb_buffer_load_ctrl;

    localparam int NREGS = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] chunk = 8'h00;
    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    buffer_load_ctrl_if #(.BUFF_CNT_W(3)) bus ();

    buffer_load_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic       rdy;
        logic       wr;
        logic [2:0] cnt;
        logic       bsy;
        logic       cs;
    } st_t;

    st_t        st_q[$];
    int         wr_q[$];
    int         cs_q[$];
    logic [7:0] shadow [NREGS];
    logic [7:0] m_buf  [NREGS];

    // transaction-level model: phase of the load protocol plus beats taken so far
    bit m_loading = 1'b0;
    bit m_pulse   = 1'b0;
    bit m_running = 1'b0;
    int m_beats   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // sequence_buffer stand-in: captures the chunk wherever the DUT points
    always @(posedge clk) begin
        if (rst_n && bus.wr_en_buff) shadow[bus.count] <= chunk;
    end

    // monitor: pops expectations when the DUT presents outputs
    always @(negedge clk) begin
        if (rst_n) begin
            if (st_q.size() > 0) begin
                st_t e;
                e = st_q.pop_front();
                chk("in_ready",   int'(bus.in_ready),   int'(e.rdy));
                chk("wr_en_buff", int'(bus.wr_en_buff), int'(e.wr));
                chk("count",      int'(bus.count),      int'(e.cnt));
                chk("busy",       int'(bus.busy),       int'(e.bsy));
                chk("core_start", int'(bus.core_start), int'(e.cs));
            end
            if (bus.wr_en_buff) begin
                if (wr_q.size() == 0) begin
                    chk("wr_unexpected", 1, 0);
                end else begin
                    int idx;
                    idx = wr_q.pop_front();
                    chk("wr_index", int'(bus.count), idx);
                end
            end
            if (bus.core_start) begin
                if (cs_q.size() == 0) begin
                    chk("core_start_unexpected", 1, 0);
                end else begin
                    int ec;
                    ec = cs_q.pop_front();
                    chk("core_start_cycle", cyc, ec);
                    for (int i = 0; i < NREGS; i++)
                        chk($sformatf("buffer_reg%0d", i), int'(shadow[i]), int'(m_buf[i]));
                end
            end
        end
    end

    task automatic step(input logic s, input logic v, input logic d, input logic [7:0] c);
        st_t e;
        @(posedge clk);
        #1;
        bus.start     = s;
        bus.in_valid  = v;
        bus.core_done = d;
        chunk         = c;
        e.rdy = m_loading;
        e.wr  = m_loading && v;
        e.cnt = 3'(m_beats);
        e.bsy = m_loading || m_pulse || m_running;
        e.cs  = m_pulse;
        st_q.push_back(e);
        if (e.wr) begin
            wr_q.push_back(m_beats);
            m_buf[m_beats] = c;
            if (m_beats == NREGS - 1) cs_q.push_back(cyc + 1);
        end
        if (m_loading) begin
            if (v) begin
                m_beats++;
                if (m_beats == NREGS) begin
                    m_beats   = 0;
                    m_loading = 1'b0;
                    m_pulse   = 1'b1;
                end
            end
        end else if (m_pulse) begin
            m_pulse   = 1'b0;
            m_running = 1'b1;
        end else if (m_running) begin
            if (d) m_running = 1'b0;
        end else if (s) begin
            m_loading = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_count",      int'(bus.count),      0);
        chk("rst_wr_en_buff", int'(bus.wr_en_buff), 0);
        chk("rst_in_ready",   int'(bus.in_ready),   0);
        chk("rst_core_start", int'(bus.core_start), 0);
        chk("rst_busy",       int'(bus.busy),       0);
        m_loading = 1'b0;
        m_pulse   = 1'b0;
        m_running = 1'b0;
        m_beats   = 0;
        st_q.delete();
        wr_q.delete();
        cs_q.delete();
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.core_done = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.core_done = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            shadow[i] = 8'h00;
            m_buf[i]  = 8'h00;
        end
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        do_reset();

        // back-to-back load with fixed chunks, then valid noise in DONE/RUN/IDLE
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < NREGS; i++) step(1'b0, 1'b1, 1'b0, 8'((i + 1) * 17));
        repeat (4) step(1'b0, 1'b1, 1'b0, 8'hFF);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        repeat (3) step(1'b0, 1'b1, 1'b0, 8'hEE);

        // gapped load, then start while running and start coinciding with core_done
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 2 * NREGS; i++) step(1'b0, (i % 2) == 0, 1'b0, 8'($urandom));
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        repeat (2) step(1'b0, 1'b0, 1'b0, 8'h00);

        // start pulsed mid-load, core_done idle noise
        step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'($urandom));
        step(1'b1, 1'b1, 1'b0, 8'($urandom));
        repeat (8) step(1'b0, 1'b1, 1'b0, 8'($urandom));
        step(1'b0, 1'b0, 1'b1, 8'h00);

        // reset after three beats, then a full reload from index 0
        step(1'b1, 1'b0, 1'b0, 8'h00);
        repeat (3) step(1'b0, 1'b1, 1'b0, 8'($urandom));
        do_reset();
        step(1'b1, 1'b0, 1'b0, 8'h00);
        repeat (NREGS) step(1'b0, 1'b1, 1'b0, 8'($urandom));
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h00);

        // randomized traffic
        repeat (600)
            step($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 5) == 0, 8'($urandom));
        repeat (2) step(1'b0, 1'b0, 1'b0, 8'h00);
        @(posedge clk);
        #6;
        chk("pending_writes", wr_q.size(), 0);
        chk("pending_core_start", cs_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
